// File: rtl/fxp_div_pkg.sv
// Shared types and defaults for the fixed-point unsigned divider operand sequencer.
package fxp_div_pkg;

   typedef enum logic [2:0] {
      S_A       = 3'd0,
      S_B       = 3'd1,
      START     = 3'd2,
      WAIT_DONE = 3'd3,
      OUT       = 3'd4
   } state_t;

   localparam int DATA_W_DEF  = 8;
   localparam int TIMEOUT_DEF = 64;

   // Saturated error value: the low 'width' bits set, up to 32 bits.
   function automatic logic [31:0] sat_all_ones(input int width);
      if (width >= 32) begin
         return '1;
      end
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/fxp_div_watchdog.sv
// Clear/enable cycle counter that flags expiry when it reaches TIMEOUT_CYC-1.
module fxp_div_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/fxp_udiv_operand_sequencer.sv
// Pairs input bytes into {dividend, divisor}, launches one divide, returns the quotient.
// Optional FXP_DIV_ZERO_BYPASS_EN: zero divisor returns the error value without a launch.
module fxp_udiv_operand_sequencer
   import fxp_div_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              div_start,
   output logic [DATA_W-1:0] div_dividend,
   output logic [DATA_W-1:0] div_divisor,
   input  logic              div_done,
   input  logic [DATA_W-1:0] div_quotient,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_err,
   output state_t            debug_state
);

   // Handshakes: a byte moves on s_valid && s_ready at posedge, a result on
   // m_valid && m_ready; valid never waits on ready and data is held until taken.

   localparam logic [DATA_W-1:0] ERR_VAL = DATA_W'(sat_all_ones(DATA_W));

   state_t state;
   logic   wd_expired;

   fxp_div_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state == START),
      .enable  (state == WAIT_DONE),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_A;
         s_ready      <= 1'b0;
         div_start    <= 1'b0;
         m_valid      <= 1'b0;
         m_err        <= 1'b0;
         m_data       <= '0;
         div_dividend <= '0;
         div_divisor  <= '0;
      end else begin
         case (state)
            S_A: begin
               s_ready <= 1'b1;
               if (s_valid && s_ready) begin
                  div_dividend <= s_data;
                  state        <= S_B;
               end
            end
            S_B: begin
               if (s_valid && s_ready) begin
                  div_divisor <= s_data;
                  s_ready     <= 1'b0;
`ifdef FXP_DIV_ZERO_BYPASS_EN
                  if (s_data == '0) begin
                     m_data  <= ERR_VAL;
                     m_err   <= 1'b1;
                     m_valid <= 1'b1;
                     state   <= OUT;
                  end else begin
                     div_start <= 1'b1;
                     state     <= START;
                  end
`else
                  div_start <= 1'b1;
                  state     <= START;
`endif
               end
            end
            START: begin
               div_start <= 1'b0;
               state     <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // Completion takes priority over a same-cycle watchdog expiry.
               if (div_done) begin
                  m_data  <= div_quotient;
                  m_err   <= 1'b0;
                  m_valid <= 1'b1;
                  state   <= OUT;
               end else if (wd_expired) begin
                  m_data  <= ERR_VAL;
                  m_err   <= 1'b1;
                  m_valid <= 1'b1;
                  state   <= OUT;
               end
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  s_ready <= 1'b1;
                  state   <= S_A;
               end
            end
            default: begin
               state     <= S_A;
               s_ready   <= 1'b0;
               div_start <= 1'b0;
               m_valid   <= 1'b0;
            end
         endcase
      end
   end

   assign debug_state = state;

endmodule

// File: tb/tb_fxp_udiv_operand_sequencer.sv
// Bench for fxp_udiv_operand_sequencer: vector table plus reset/stall/timeout sequences.
module tb_fxp_udiv_operand_sequencer;
   import fxp_div_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_data = 8'h00;
   logic       div_start;
   logic [7:0] div_dividend;
   logic [7:0] div_divisor;
   logic       div_done = 1'b0;
   logic [7:0] div_quotient = 8'h00;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_err;
   state_t     debug_state;

   fxp_udiv_operand_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_done     (div_done),
      .div_quotient (div_quotient),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_err        (m_err),
      .debug_state  (debug_state)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- divider model ----------------
   int         dm_lat = 0;   // cycles from div_start to div_done; 0 = never
   int         dm_cnt = 0;
   bit         dm_pending = 1'b0;
   logic [7:0] dm_q = 8'h00;
   int         start_count = 0;
   int         start_cyc = 0;

   always @(negedge clk) begin
      div_done     = 1'b0;
      div_quotient = 8'($urandom_range(0, 255));
      if (!reset_n) begin
         dm_pending = 1'b0;
      end else begin
         if (dm_pending) begin
            dm_cnt = dm_cnt - 1;
            if (dm_cnt == 0) begin
               div_done     = 1'b1;
               div_quotient = dm_q;
               dm_pending   = 1'b0;
            end
         end
         if (div_start) begin
            start_count = start_count + 1;
            start_cyc   = cyc;
            dm_q = (div_divisor != 8'h00) ? (div_dividend / div_divisor) : 8'hAA;
            if (dm_lat > 0) begin
               dm_cnt     = dm_lat;
               dm_pending = 1'b1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [8:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         lat;
      int         stall;
      logic [8:0] exp;     // {m_err, m_data}
      bit         bypass;
   } vec_t;

   task automatic send_byte(input logic [7:0] d);
      int n;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("s_ready_wait", s_ready, 1);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic run_op(input vec_t v);
      logic [8:0] got;
      logic [8:0] exp;
      logic [7:0] hd;
      int n;
      int sc0;
      int exp_lat;
      dm_lat = v.lat;
      exp_q.push_back(v.exp);
      sc0 = start_count;
      send_byte(v.a);
      send_byte(v.b);
      @(negedge clk);
      if (v.bypass) begin
         check("bypass_no_start", div_start, 0);
         check("bypass_valid", m_valid, 1);
      end else begin
         check("start_pulse", div_start, 1);
         check("dividend", div_dividend, v.a);
         check("divisor", div_divisor, v.b);
         check("s_ready_busy", s_ready, 0);
         @(negedge clk);
         check("start_one_cycle", div_start, 0);
      end
      n = 0;
      while (!m_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("m_valid_seen", m_valid, 1);
      check("start_count", start_count - sc0, v.bypass ? 0 : 1);
      if (!v.bypass) begin
         exp_lat = (v.lat >= 1 && v.lat <= 64) ? v.lat + 1 : 65;
         check("latency", cyc - start_cyc, exp_lat);
         check("operands_held", {div_dividend, div_divisor}, {v.a, v.b});
      end
      if (v.stall > 0) begin
         got = {m_err, m_data};
         hd  = div_dividend;
         s_valid = 1'b1;
         s_data  = 8'h77;
         for (int i = 0; i < v.stall; i++) begin
            @(negedge clk);
            check("stall_valid", m_valid, 1);
            check("stall_data", {m_err, m_data}, got);
            check("stall_s_ready", s_ready, 0);
            check("stall_dividend", div_dividend, hd);
         end
         s_valid = 1'b0;
      end
      got = {m_err, m_data};
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
      if (exp_q.size() == 0) begin
         check("sb_underflow", 1, 0);
      end else begin
         exp = exp_q.pop_front();
         check("result", got, exp);
      end
      @(negedge clk);
      check("m_valid_drop", m_valid, 0);
      check("back_to_s_a", debug_state, S_A);
      check("s_ready_idle", s_ready, 1);
   endtask

   // ---------------- global time limit ----------------
   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "time limit");
   end

   // ---------------- test ----------------
   vec_t tbl[10];
   vec_t rv;

   initial begin
      tbl[0] = '{8'h40, 8'h20, 10, 0,  {1'b0, 8'h02}, 1'b0};
      tbl[1] = '{8'h90, 8'h07, 1,  0,  {1'b0, 8'h14}, 1'b0};
      tbl[2] = '{8'hFF, 8'h01, 3,  0,  {1'b0, 8'hFF}, 1'b0};
      tbl[3] = '{8'h05, 8'h09, 2,  0,  {1'b0, 8'h00}, 1'b0};
      tbl[4] = '{8'hC8, 8'h0A, 64, 0,  {1'b0, 8'h14}, 1'b0};
      tbl[5] = '{8'h33, 8'h03, 0,  0,  {1'b1, 8'hFF}, 1'b0};
      tbl[6] = '{8'h21, 8'h05, 65, 0,  {1'b1, 8'hFF}, 1'b0};
      tbl[7] = '{8'h80, 8'h10, 4,  20, {1'b0, 8'h08}, 1'b0};
      tbl[8] = '{8'h77, 8'h11, 2,  0,  {1'b0, 8'h07}, 1'b0};
`ifdef FXP_DIV_ZERO_BYPASS_EN
      tbl[9] = '{8'h5A, 8'h00, 3,  0,  {1'b1, 8'hFF}, 1'b1};
`else
      tbl[9] = '{8'h5A, 8'h00, 3,  0,  {1'b0, 8'hAA}, 1'b0};
`endif

      // reset state
      repeat (3) @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_div_start", div_start, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_err", m_err, 0);
      check("rst_m_data", m_data, 0);
      check("rst_operands", {div_dividend, div_divisor}, 0);
      check("rst_state", debug_state, S_A);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i]);
      end

      // reset while waiting on the divider drops the operation
      dm_lat = 0;
      send_byte(8'h55);
      send_byte(8'h03);
      repeat (10) @(negedge clk);
      check("pre_reset_state", debug_state, WAIT_DONE);
      reset_n = 1'b0;
      #1;
      check("mid_rst_s_ready", s_ready, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_m_data", {m_err, m_data}, 0);
      check("mid_rst_operands", {div_dividend, div_divisor}, 0);
      check("mid_rst_state", debug_state, S_A);
      @(negedge clk);
      reset_n = 1'b1;
      rv = '{8'h10, 8'h04, 5, 0, {1'b0, 8'h04}, 1'b0};
      run_op(rv);

      // random operands with a nonzero divisor
      for (int i = 0; i < 6; i++) begin
         rv.a      = 8'($urandom_range(0, 255));
         rv.b      = 8'($urandom_range(1, 255));
         rv.lat    = $urandom_range(1, 20);
         rv.stall  = $urandom_range(0, 3);
         rv.exp    = {1'b0, rv.a / rv.b};
         rv.bypass = 1'b0;
         run_op(rv);
      end

      check("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
